// File: rtl/posit_mul_arbiter.sv
// Round-robin front end that shares one pipelined posit multiplier among NUM_REQ requesters.
// Each issued operation carries its requester ID down a tag pipeline so the product returns to its issuer.
module posit_mul_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ES      = 3,
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 2,
    parameter int IDW     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_valid,
    input  logic [WIDTH-1:0]         mul_res,
    output logic                     rsp_valid,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]       busy,
    output logic [15:0]              issue_cnt
);
    // Stage 0 is loaded at the issue edge and the last stage must line up with the edge
    // after mul_res is valid, hence one stage more than the multiplier latency.
    localparam int TAG_STAGES = MUL_LAT + 1;
    localparam int LAST       = TAG_STAGES - 1;

    if (NUM_REQ < 2 || MUL_LAT < 1 || IDW < $clog2(NUM_REQ) || ES < 0) begin : g_param_check
        $error("posit_mul_arbiter: illegal parameter combination");
    end

    logic [WIDTH-1:0]      mul_a_q, mul_b_q, rsp_data_q;
    logic                  mul_valid_q, rsp_valid_q;
    logic [IDW-1:0]        rsp_id_q;
    logic [NUM_REQ-1:0]    busy_q, busy_d;
    logic [IDW-1:0]        rr_q, rr_d;
    logic [15:0]           issue_cnt_q;
    logic [TAG_STAGES-1:0] tag_vld_q;
    logic [IDW-1:0]        tag_id_q [TAG_STAGES];

    logic [WIDTH-1:0]      op_a [NUM_REQ];
    logic [WIDTH-1:0]      op_b [NUM_REQ];
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant_oh;
    logic                  grant_any;
    logic [IDW-1:0]        grant_id;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign op_a[gi]     = req_a[gi*WIDTH +: WIDTH];
        assign op_b[gi]     = req_b[gi*WIDTH +: WIDTH];
        assign eligible[gi] = req_valid[gi] & ~busy_q[gi];
    end

    // First eligible requester at or after the round-robin pointer, wrapping.
    always_comb begin : arb
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        grant_oh  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_q) + i) % NUM_REQ;
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
        if (grant_any) begin
            grant_oh[grant_id] = 1'b1;
        end
    end

    assign req_ready = rst_n ? grant_oh : '0;

    // A response frees its requester before a same-edge grant can claim it again.
    always_comb begin
        busy_d = busy_q;
        rr_d   = rr_q;
        if (tag_vld_q[LAST]) begin
            busy_d[tag_id_q[LAST]] = 1'b0;
        end
        if (grant_any) begin
            busy_d[grant_id] = 1'b1;
            rr_d = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            busy_q      <= '0;
            rr_q        <= '0;
            issue_cnt_q <= '0;
            tag_vld_q   <= '0;
            for (int s = 0; s < TAG_STAGES; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            mul_valid_q <= grant_any;
            if (grant_any) begin
                mul_a_q     <= op_a[grant_id];
                mul_b_q     <= op_b[grant_id];
                issue_cnt_q <= issue_cnt_q + 16'd1;
            end
            tag_vld_q   <= {tag_vld_q[LAST-1:0], grant_any};
            tag_id_q[0] <= grant_id;
            for (int s = 1; s < TAG_STAGES; s++) begin
                tag_id_q[s] <= tag_id_q[s-1];
            end
            rsp_valid_q <= tag_vld_q[LAST];
            if (tag_vld_q[LAST]) begin
                rsp_id_q   <= tag_id_q[LAST];
                rsp_data_q <= mul_res;
            end
            busy_q <= busy_d;
            rr_q   <= rr_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_valid = mul_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_posit_mul_arbiter.sv
// Directed bench for posit_mul_arbiter; a behavioural MUL_LAT-deep multiplier model drives mul_res
// and outputs garbage outside the valid window so misaligned captures are visible.
module tb_posit_mul_arbiter;
    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;
    localparam int MUL_LAT = 2;
    localparam int IDW     = 2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic                     mul_valid;
    logic [WIDTH-1:0]         mul_res;
    logic                     rsp_valid;
    logic [IDW-1:0]           rsp_id;
    logic [WIDTH-1:0]         rsp_data;
    logic [NUM_REQ-1:0]       busy;
    logic [15:0]              issue_cnt;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mpipe [MUL_LAT];
    logic [WIDTH-1:0] op_a_tab [NUM_REQ];
    logic [WIDTH-1:0] op_b_tab [NUM_REQ];

    posit_mul_arbiter #(
        .WIDTH(WIDTH), .ES(3), .NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT), .IDW(IDW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid), .mul_res(mul_res),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    // Hand-worked posit32/es3 products for the directed operands, signature for anything else.
    function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h8000_0000 || b == 32'h8000_0000) return 32'h8000_0000;
        if (a == 32'h4000_0000) return b;
        if (b == 32'h4000_0000) return a;
        if (a == 32'h4800_0000 && b == 32'hC000_0000) return 32'hB800_0000;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    always @(posedge clk) begin
        mpipe[0] <= mul_valid ? mul_model(mul_a, mul_b) : 32'hDEAD_BEEF;
        for (int i = 1; i < MUL_LAT; i++) begin
            mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_res = mpipe[MUL_LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b);
        req_a[r*WIDTH +: WIDTH] = a;
        req_b[r*WIDTH +: WIDTH] = b;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mul_valid"}, 32'(mul_valid), 32'h0);
        check({tag, "_mul_a"}, mul_a, 32'h0);
        check({tag, "_mul_b"}, mul_b, 32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'h0);
        check({tag, "_rsp_data"}, rsp_data, 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_issue_cnt"}, 32'(issue_cnt), 32'h0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    endtask

    // One request from requester r; checks grant, latency, id and routed product.
    task automatic run_single(input string tag, input int r, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp);
        int n;
        set_op(r, a, b);
        req_valid = '0;
        req_valid[r] = 1'b1;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(1) << r);
        @(negedge clk);
        req_valid = '0;
        check({tag, "_mul_a"}, mul_a, a);
        n = 0;
        while (n < 8) begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
        end
        check({tag, "_latency"}, 32'(n), 32'(MUL_LAT + 1));
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'(r));
        check({tag, "_rsp_data"}, rsp_data, exp);
        $display("txn %s: req %0d a=%h b=%h -> id=%0d data=%h", tag, r, a, b, rsp_id, rsp_data);
        @(negedge clk);
    endtask

    initial begin
        int c1, c3, d, rsp_seen;
        bit found;
        op_a_tab = '{32'h1234_5678, 32'h2345_6789, 32'h3456_789A, 32'h0ABC_DEF1};
        op_b_tab = '{32'h0F0F_1111, 32'h5A5A_2222, 32'h3C3C_3333, 32'h6666_4444};
        req_a = '0;
        req_b = '0;
        req_valid = 4'hF;

        // Reset state, with every requester asking during reset.
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        $display("txn reset: outputs idle, req_ready=%b", req_ready);

        // Single op on requester 0: 1.0 * 1.0.
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
        set_op(0, 32'h4000_0000, 32'h4000_0000);
        req_valid = 4'b0001;
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        check("single_mul_valid", 32'(mul_valid), 32'h1);
        check("single_mul_a", mul_a, 32'h4000_0000);
        check("single_mul_b", mul_b, 32'h4000_0000);
        check("single_busy", 32'(busy), 32'h1);
        check("single_cnt", 32'(issue_cnt), 32'h1);
        check("single_ready_busy", 32'(req_ready), 32'h0);
        @(negedge clk);
        check("single_mul_valid_drop", 32'(mul_valid), 32'h0);
        check("single_rsp_e1", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        check("single_rsp_e2", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        check("single_rsp_e3", 32'(rsp_valid), 32'h1);
        check("single_rsp_id", 32'(rsp_id), 32'h0);
        check("single_rsp_data", rsp_data, 32'h4000_0000);
        check("single_busy_clear", 32'(busy), 32'h0);
        $display("txn single: req 0 -> id=%0d data=%h", rsp_id, rsp_data);
        @(negedge clk);
        check("single_rsp_pulse", 32'(rsp_valid), 32'h0);

        // All four requesters valid straight out of reset.
        rst_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_op(i, op_a_tab[i], op_b_tab[i]);
        req_valid = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("all_ready0", 32'(req_ready), 32'h1);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check($sformatf("all_mul_valid%0d", n), 32'(mul_valid), 32'h1);
            check($sformatf("all_mul_a%0d", n), mul_a, op_a_tab[n % NUM_REQ]);
            if (n == 2) check("all_ready_no_regrant", 32'(req_ready), 32'h8);
            if (n == 3) begin
                check("all_cnt4", 32'(issue_cnt), 32'h4);
                check("all_ready_regrant", 32'(req_ready), 32'h1);
            end
            if (n >= 3) begin
                check($sformatf("all_rsp_valid%0d", n), 32'(rsp_valid), 32'h1);
                check($sformatf("all_rsp_id%0d", n), 32'(rsp_id), 32'((n - 3) % NUM_REQ));
                check($sformatf("all_rsp_data%0d", n), rsp_data,
                      mul_model(op_a_tab[(n - 3) % NUM_REQ], op_b_tab[(n - 3) % NUM_REQ]));
                $display("txn all: step %0d issue a=%h rsp id=%0d data=%h", n, mul_a, rsp_id, rsp_data);
            end else begin
                check($sformatf("all_rsp_valid%0d", n), 32'(rsp_valid), 32'h0);
                $display("txn all: step %0d issue a=%h", n, mul_a);
            end
        end
        req_valid = '0;
        repeat (5) @(negedge clk);

        // Fairness: move pointer to 2 via a single op on requester 1, then hold 1 and 3.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        check("fair_idle", 32'(busy), 32'h0);
        req_valid = 4'b1010;
        #1;
        check("fair_first_ready", 32'(req_ready), 32'h8);
        @(negedge clk);
        check("fair_first_grant", mul_a, op_a_tab[3]);
        #1;
        check("fair_second_ready", 32'(req_ready), 32'h2);
        @(negedge clk);
        check("fair_second_grant", mul_a, op_a_tab[1]);
        c1 = 0;
        c3 = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (mul_valid && mul_a == op_a_tab[1]) c1++;
            else if (mul_valid && mul_a == op_a_tab[3]) c3++;
        end
        d = (c1 > c3) ? c1 - c3 : c3 - c1;
        check("fair_diff_le1", 32'(d <= 1), 32'h1);
        check("fair_total", 32'(c1 + c3), 32'd50);
        $display("txn fair: grants req1=%0d req3=%0d", c1, c3);
        req_valid = '0;
        repeat (5) @(negedge clk);

        // Posit products routed back to the issuer; NaR forwarded bit-exact.
        run_single("mul4xm1", 2, 32'h4800_0000, 32'hC000_0000, 32'hB800_0000);
        run_single("nar", 1, 32'h8000_0000, 32'h5000_0000, 32'h8000_0000);

        // Reset with two operations in flight.
        req_valid = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'h3);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        rsp_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        check("midrst_no_rsp", 32'(rsp_seen), 32'h0);
        check("midrst_busy_after", 32'(busy), 32'h0);
        $display("txn midrst: responses after release=%0d", rsp_seen);

        // Issue counter wrap.
        for (int i = 0; i < NUM_REQ; i++) set_op(i, op_a_tab[i], op_b_tab[i]);
        req_valid = 4'hF;
        found = 1'b0;
        for (int n = 0; n < 70000; n++) begin
            @(negedge clk);
            if (issue_cnt == 16'hFFFF) begin
                found = 1'b1;
                break;
            end
        end
        check("wrap_reach_ffff", 32'(found), 32'h1);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (mul_valid) break;
        end
        check("wrap_mul_valid", 32'(mul_valid), 32'h1);
        check("wrap_zero", 32'(issue_cnt), 32'h0);
        $display("txn wrap: issue_cnt after wrap=%h", issue_cnt);
        req_valid = '0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
